gt_pll_seq: RTL and testbench

GT_PLL_SEQ -- requirements
Module: gt_pll_seq

---
 rtl/gt_pll_seq.sv | 191 +++++++++++++++++++
 tb/tb_gt_pll_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/gt_pll_seq.sv
`default_nettype none
// ============================================================================
//  Module   : gt_pll_seq
//  Purpose  : Power-up / reset / lock sequencer for up to two GT common PLLs.
//             One independent Moore FSM per PLL with lock-timeout retry,
//             reference-clock-loss recovery and an aggregate ready flag.
//  Revision : 1.0  initial release
// ============================================================================
module gt_pll_seq #(
    parameter int NUM_PLL      = 2,
    parameter int PD_CYCLES    = 16,
    parameter int RST_CYCLES   = 8,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int MAX_RETRY    = 3
) (
    input  logic                   DRP_CLK,
    input  logic                   RST,
    input  logic [NUM_PLL-1:0]     EN,
    input  logic [NUM_PLL-1:0]     PLL_LOCK,
    input  logic [NUM_PLL-1:0]     PLL_REFCLKLOST,
    output logic [NUM_PLL-1:0]     PLL_PD,
    output logic [NUM_PLL-1:0]     PLL_RESET,
    output logic [NUM_PLL-1:0]     PLL_READY,
    output logic [NUM_PLL-1:0]     PLL_FAIL,
    output logic                   ALL_READY,
    output logic [2*NUM_PLL-1:0]   RETRY_CNT
);

    // Largest interval any counter must time; counters only count to (N-1).
    localparam int MAX_A   = (PD_CYCLES > RST_CYCLES) ? PD_CYCLES : RST_CYCLES;
    localparam int MAX_CYC = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int RTY_W   = ($clog2(MAX_RETRY + 1) > 2) ? $clog2(MAX_RETRY + 1) : 2;

    localparam logic [CNT_W-1:0] PD_LAST  = CNT_W'(PD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
    localparam logic [RTY_W-1:0] RTY_SAT  = RTY_W'(3);

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_PWRUP     = 3'd1,
        ST_RSTP      = 3'd2,
        ST_WAIT_LOCK = 3'd3,
        ST_LOCKED    = 3'd4,
        ST_FAIL      = 3'd5
    } state_t;

    logic [NUM_PLL-1:0] lock_m, lock_s;
    logic [NUM_PLL-1:0] lost_m, lost_s;

    // Two-flop synchronisers for the asynchronous PLL status inputs.
    always_ff @(posedge DRP_CLK) begin
        if (RST) begin
            lock_m <= '0;
            lock_s <= '0;
            lost_m <= '0;
            lost_s <= '0;
        end else begin
            lock_m <= PLL_LOCK;
            lock_s <= lock_m;
            lost_m <= PLL_REFCLKLOST;
            lost_s <= lost_m;
        end
    end

    generate
        for (genvar g = 0; g < NUM_PLL; g++) begin : g_pll
            state_t           state, state_nx;
            logic [CNT_W-1:0] cnt, cnt_nx;
            logic [RTY_W-1:0] retry, retry_nx;
            logic             pd_q, reset_q, ready_q, fail_q;
            logic [1:0]       rcnt_q;

            // Next-state, counter and retry logic; EN beats lost beats lock/timeout.
            always_comb begin
                state_nx = state;
                cnt_nx   = cnt;
                retry_nx = retry;
                if (!EN[g]) begin
                    state_nx = ST_OFF;
                    cnt_nx   = '0;
                    retry_nx = '0;
                end else begin
                    case (state)
                        ST_OFF: begin
                            state_nx = ST_PWRUP;
                            cnt_nx   = '0;
                        end
                        ST_PWRUP: begin
                            if (cnt == PD_LAST) begin
                                state_nx = ST_RSTP;
                                cnt_nx   = '0;
                            end else begin
                                cnt_nx = cnt + CNT_W'(1);
                            end
                        end
                        ST_RSTP: begin
                            // Reference clock missing: keep the PLL in reset and restart the count.
                            if (lost_s[g]) begin
                                cnt_nx = '0;
                            end else if (cnt == RST_LAST) begin
                                state_nx = ST_WAIT_LOCK;
                                cnt_nx   = '0;
                            end else begin
                                cnt_nx = cnt + CNT_W'(1);
                            end
                        end
                        ST_WAIT_LOCK: begin
                            if (lost_s[g]) begin
                                state_nx = ST_RSTP;
                                cnt_nx   = '0;
                            end else if (lock_s[g]) begin
                                // Lock wins over a coincident timeout.
                                state_nx = ST_LOCKED;
                                cnt_nx   = '0;
                                retry_nx = '0;
                            end else if (cnt == TO_LAST) begin
                                cnt_nx = '0;
                                if (retry < RTY_MAX) begin
                                    retry_nx = retry + RTY_W'(1);
                                    state_nx = ST_RSTP;
                                end else begin
                                    state_nx = ST_FAIL;
                                end
                            end else begin
                                cnt_nx = cnt + CNT_W'(1);
                            end
                        end
                        ST_LOCKED: begin
                            // Lost lock or lost refclk restarts without spending a retry.
                            if (lost_s[g] || !lock_s[g]) begin
                                state_nx = ST_RSTP;
                                cnt_nx   = '0;
                            end
                        end
                        ST_FAIL: begin
                            state_nx = ST_FAIL;
                        end
                        default: begin
                            state_nx = ST_OFF;
                            cnt_nx   = '0;
                            retry_nx = '0;
                        end
                    endcase
                end
            end

            // State register with outputs decoded from the next state (registered Moore).
            always_ff @(posedge DRP_CLK) begin
                if (RST) begin
                    state   <= ST_OFF;
                    cnt     <= '0;
                    retry   <= '0;
                    pd_q    <= 1'b1;
                    reset_q <= 1'b1;
                    ready_q <= 1'b0;
                    fail_q  <= 1'b0;
                    rcnt_q  <= 2'd0;
                end else begin
                    state   <= state_nx;
                    cnt     <= cnt_nx;
                    retry   <= retry_nx;
                    pd_q    <= (state_nx == ST_OFF) || (state_nx == ST_FAIL);
                    reset_q <= !((state_nx == ST_WAIT_LOCK) || (state_nx == ST_LOCKED));
                    ready_q <= (state_nx == ST_LOCKED);
                    fail_q  <= (state_nx == ST_FAIL);
                    rcnt_q  <= (retry_nx > RTY_SAT) ? 2'd3 : retry_nx[1:0];
                end
            end

            assign PLL_PD[g]           = pd_q;
            assign PLL_RESET[g]        = reset_q;
            assign PLL_READY[g]        = ready_q;
            assign PLL_FAIL[g]         = fail_q;
            assign RETRY_CNT[2*g+1:2*g] = rcnt_q;
        end
    endgenerate

    // Aggregate ready: every enabled PLL ready, and at least one enabled.
    always_ff @(posedge DRP_CLK) begin
        if (RST) begin
            ALL_READY <= 1'b0;
        end else begin
            ALL_READY <= (|EN) && (&(PLL_READY | ~EN));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gt_pll_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gt_pll_seq
//  Purpose  : Directed self-checking bench for gt_pll_seq (2 PLLs,
//             PD=16, RST=8, LOCK_TIMEOUT=100, MAX_RETRY=3).
//  Revision : 1.0  initial release
// ============================================================================
module tb_gt_pll_seq;

    logic       clk;
    logic       rst;
    logic [1:0] en;
    logic [1:0] lock;
    logic [1:0] lost;
    logic [1:0] pd;
    logic [1:0] rs;
    logic [1:0] ready;
    logic [1:0] fail;
    logic       all_ready;
    logic [3:0] retry_cnt;
    logic [1:0] allow;

    int n_tests;
    int n_fail;

    // Behavioural PLL: locks whenever allowed, powered, out of reset and clocked.
    assign lock = allow & ~rs & ~pd & ~lost;

    gt_pll_seq #(
        .NUM_PLL      (2),
        .PD_CYCLES    (16),
        .RST_CYCLES   (8),
        .LOCK_TIMEOUT (100),
        .MAX_RETRY    (3)
    ) dut (
        .DRP_CLK        (clk),
        .RST            (rst),
        .EN             (en),
        .PLL_LOCK       (lock),
        .PLL_REFCLKLOST (lost),
        .PLL_PD         (pd),
        .PLL_RESET      (rs),
        .PLL_READY      (ready),
        .PLL_FAIL       (fail),
        .ALL_READY      (all_ready),
        .RETRY_CNT      (retry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst   = 1'b1;
        en    = 2'b00;
        lost  = 2'b00;
        allow = 2'b00;
        repeat (3) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        en    = 2'b11;
        lost  = 2'b00;
        allow = 2'b11;
        repeat (2) tick();
        n_tests++; if (pd !== 2'b11) begin n_fail++; $display("FAIL reset_pd got %b exp 11", pd); end
        n_tests++; if (rs !== 2'b11) begin n_fail++; $display("FAIL reset_rst got %b exp 11", rs); end
        n_tests++; if (ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready got %b exp 00", ready); end
        n_tests++; if (fail !== 2'b00) begin n_fail++; $display("FAIL reset_fail got %b exp 00", fail); end
        n_tests++; if (all_ready !== 1'b0) begin n_fail++; $display("FAIL reset_all_ready got %b exp 0", all_ready); end
        n_tests++; if (retry_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_retry got %h exp 0", retry_cnt); end
        rst = 1'b0;
        en  = 2'b00;
        tick();
    endtask

    // PLL0 bring-up timeline with lock available as soon as reset is released.
    task automatic test_bringup;
        do_reset();
        allow = 2'b01;
        en    = 2'b01;
        for (int n = 1; n <= 30; n++) begin
            tick();
            n_tests++; if (pd[0] !== 1'b0) begin n_fail++; $display("FAIL bringup_pd0 edge %0d got %b exp 0", n, pd[0]); end
            n_tests++; if (rs[0] !== (n < 25)) begin n_fail++; $display("FAIL bringup_rst0 edge %0d got %b exp %b", n, rs[0], (n < 25)); end
            n_tests++; if (ready[0] !== (n >= 28)) begin n_fail++; $display("FAIL bringup_ready0 edge %0d got %b exp %b", n, ready[0], (n >= 28)); end
        end
        n_tests++; if (all_ready !== 1'b1) begin n_fail++; $display("FAIL bringup_all_ready got %b exp 1", all_ready); end
        n_tests++; if (retry_cnt !== 4'd0) begin n_fail++; $display("FAIL bringup_retry got %h exp 0", retry_cnt); end
        n_tests++; if (pd[1] !== 1'b1) begin n_fail++; $display("FAIL bringup_pd1_off got %b exp 1", pd[1]); end
    endtask

    // 50-cycle refclk loss on a locked PLL0 (continues from bring-up).
    task automatic test_refclk_lost;
        lost[0] = 1'b1;
        for (int n = 1; n <= 66; n++) begin
            tick();
            n_tests++; if (ready[0] !== ((n < 3) || (n >= 63))) begin n_fail++; $display("FAIL lost_ready0 edge %0d got %b exp %b", n, ready[0], ((n < 3) || (n >= 63))); end
            n_tests++; if (rs[0] !== ((n >= 3) && (n < 60))) begin n_fail++; $display("FAIL lost_rst0 edge %0d got %b exp %b", n, rs[0], ((n >= 3) && (n < 60))); end
            if (n == 50) lost[0] = 1'b0;
        end
        n_tests++; if (retry_cnt[1:0] !== 2'd0) begin n_fail++; $display("FAIL lost_retry got %0d exp 0", retry_cnt[1:0]); end
    endtask

    // Lock never arrives: three retries, then FAIL; EN low clears it.
    task automatic test_retry_fail;
        do_reset();
        allow = 2'b00;
        en    = 2'b01;
        for (int n = 1; n <= 452; n++) begin
            tick();
            case (n)
                124: begin
                    n_tests++; if (rs[0] !== 1'b0 || retry_cnt[1:0] !== 2'd0) begin n_fail++; $display("FAIL retry_e124 rst %b retry %0d exp 0 0", rs[0], retry_cnt[1:0]); end
                end
                125: begin
                    n_tests++; if (rs[0] !== 1'b1 || retry_cnt[1:0] !== 2'd1) begin n_fail++; $display("FAIL retry_e125 rst %b retry %0d exp 1 1", rs[0], retry_cnt[1:0]); end
                end
                233: begin
                    n_tests++; if (retry_cnt[1:0] !== 2'd2) begin n_fail++; $display("FAIL retry_e233 got %0d exp 2", retry_cnt[1:0]); end
                end
                341: begin
                    n_tests++; if (retry_cnt[1:0] !== 2'd3 || fail[0] !== 1'b0) begin n_fail++; $display("FAIL retry_e341 retry %0d fail %b exp 3 0", retry_cnt[1:0], fail[0]); end
                end
                448: begin
                    n_tests++; if (fail[0] !== 1'b0 || rs[0] !== 1'b0) begin n_fail++; $display("FAIL retry_e448 fail %b rst %b exp 0 0", fail[0], rs[0]); end
                end
                449: begin
                    n_tests++; if (fail[0] !== 1'b1 || pd[0] !== 1'b1 || rs[0] !== 1'b1 || retry_cnt[1:0] !== 2'd3) begin
                        n_fail++; $display("FAIL retry_e449 fail %b pd %b rst %b retry %0d exp 1 1 1 3", fail[0], pd[0], rs[0], retry_cnt[1:0]);
                    end
                end
                452: begin
                    n_tests++; if (fail[0] !== 1'b1) begin n_fail++; $display("FAIL retry_fail_hold got %b exp 1", fail[0]); end
                end
                default: ;
            endcase
        end
        en = 2'b00;
        tick();
        n_tests++; if (fail[0] !== 1'b0 || retry_cnt[1:0] !== 2'd0 || pd[0] !== 1'b1) begin
            n_fail++; $display("FAIL retry_off fail %b retry %0d pd %b exp 0 0 1", fail[0], retry_cnt[1:0], pd[0]);
        end
    endtask

    // Synchronous reset applied in WAIT_LOCK after two retries.
    task automatic test_rst_mid;
        do_reset();
        allow = 2'b00;
        en    = 2'b01;
        repeat (250) tick();
        n_tests++; if (retry_cnt[1:0] !== 2'd2 || rs[0] !== 1'b0) begin n_fail++; $display("FAIL rstmid_pre retry %0d rst %b exp 2 0", retry_cnt[1:0], rs[0]); end
        rst = 1'b1;
        tick();
        n_tests++; if (pd !== 2'b11 || rs !== 2'b11) begin n_fail++; $display("FAIL rstmid_pd_rst pd %b rst %b exp 11 11", pd, rs); end
        n_tests++; if (ready !== 2'b00 || fail !== 2'b00 || all_ready !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_flags ready %b fail %b all %b exp 00 00 0", ready, fail, all_ready);
        end
        n_tests++; if (retry_cnt !== 4'd0) begin n_fail++; $display("FAIL rstmid_retry got %h exp 0", retry_cnt); end
        rst = 1'b0;
        en  = 2'b00;
        tick();
    endtask

    // Both PLLs enabled, PLL1 locks 40 cycles later; then PLL1 disabled.
    task automatic test_two_plls;
        do_reset();
        allow = 2'b01;
        en    = 2'b11;
        for (int n = 1; n <= 72; n++) begin
            tick();
            n_tests++; if (ready[0] !== (n >= 28)) begin n_fail++; $display("FAIL two_ready0 edge %0d got %b exp %b", n, ready[0], (n >= 28)); end
            n_tests++; if (ready[1] !== ((n >= 68) && (n < 71))) begin n_fail++; $display("FAIL two_ready1 edge %0d got %b exp %b", n, ready[1], ((n >= 68) && (n < 71))); end
            n_tests++; if (all_ready !== (n >= 69)) begin n_fail++; $display("FAIL two_all_ready edge %0d got %b exp %b", n, all_ready, (n >= 69)); end
            if (n == 65) allow[1] = 1'b1;
            if (n == 70) en = 2'b01;
        end
        n_tests++; if (pd[1] !== 1'b1) begin n_fail++; $display("FAIL two_pd1_off got %b exp 1", pd[1]); end
        en = 2'b00;
        tick();
        n_tests++; if (all_ready !== 1'b0) begin n_fail++; $display("FAIL two_all_ready_none got %b exp 0", all_ready); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        en      = 2'b00;
        lost    = 2'b00;
        allow   = 2'b00;
        test_reset();
        test_bringup();
        test_refclk_lost();
        test_retry_fail();
        test_rst_mid();
        test_two_plls();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Run-time bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
